// File: rtl/decode_execute_pkg.sv
// decode_execute_pkg
// Shared definitions for the decode/execute stage: datapath widths,
// register-file geometry, instruction field positions and opcodes.
// Instruction layout: ir[7:6] = op, ir[5:3] = rd, ir[2:0] = rs/imm,
// and for jumps ir[5:0] = signed offset.
package decode_execute_pkg;

    localparam int DATA_W   = 8;
    localparam int CNT_W    = 16;
    localparam int INSTR_W  = 8;
    localparam int NUM_REGS = 8;
    localparam int REG_AW   = 3;
    localparam int OFF_W    = 6;

    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 6;
    localparam int RD_MSB  = 5;
    localparam int RD_LSB  = 3;
    localparam int RS_MSB  = 2;
    localparam int RS_LSB  = 0;
    localparam int OFF_MSB = 5;
    localparam int OFF_LSB = 0;

    typedef enum logic [1:0] {
        OP_MOV = 2'b00,
        OP_ADD = 2'b01,
        OP_LDI = 2'b10,
        OP_JMP = 2'b11
    } opcode_t;

endpackage

// File: rtl/decode_execute_register_file.sv
// register_file
// 8 x DATA_W register file: one synchronous write port and three
// asynchronous read ports (source, destination, debug observation).
// Ports:
//   clk, reset       clock, asynchronous active-low clear of all entries
//   we, wa, wd       write enable / address / data, written on rising edge
//   ra_rs -> rd_rs   source operand read
//   ra_rd -> rd_rd   destination operand read (for ADD)
//   ra_dbg -> rd_dbg observation read
module register_file
    import decode_execute_pkg::*;
#(
    parameter int DATA_W = decode_execute_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [REG_AW-1:0] ra_rs,
    output logic [DATA_W-1:0] rd_rs,
    input  logic [REG_AW-1:0] ra_rd,
    output logic [DATA_W-1:0] rd_rd,
    input  logic [REG_AW-1:0] ra_dbg,
    output logic [DATA_W-1:0] rd_dbg
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    // Reads are combinational: the write lands at the edge, so the next
    // instruction already sees it and no forwarding is needed.
    assign rd_rs  = regs[ra_rs];
    assign rd_rd  = regs[ra_rd];
    assign rd_dbg = regs[ra_dbg];

endmodule

// File: rtl/decode_execute.sv
// decode_execute
// Consumer end of the instruction-fetch interface. Registers the
// instruction presented by fetch, decodes it, executes MOV/ADD/LDI
// against an 8-entry register file and resolves JMP in the same cycle.
// The instruction fetched in a taken jump's shadow is squashed.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   instruction_code  instruction for the current fetch PC
//   mux_jump          comb: fetch takes PC + jump_adress on next edge
//   jump_adress       comb: signed 6-bit offset (ir[5:0])
//   wb_valid          reg: one-cycle pulse per retired MOV/ADD/LDI
//   wb_addr, wb_data  reg: destination and value of the last write
//   retire_count      reg: retired non-squashed instructions, wraps
//   dbg_sel/dbg_data  comb register-file observation port
module decode_execute
    import decode_execute_pkg::*;
#(
    parameter int DATA_W = decode_execute_pkg::DATA_W,
    parameter int CNT_W  = decode_execute_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instruction_code,
    output logic               mux_jump,
    output logic [OFF_W-1:0]   jump_adress,
    output logic               wb_valid,
    output logic [REG_AW-1:0]  wb_addr,
    output logic [DATA_W-1:0]  wb_data,
    output logic [CNT_W-1:0]   retire_count,
    input  logic [REG_AW-1:0]  dbg_sel,
    output logic [DATA_W-1:0]  dbg_data
);

    logic [INSTR_W-1:0] ir;
    logic               valid;

    opcode_t            op;
    logic [REG_AW-1:0]  rd;
    logic [REG_AW-1:0]  rs;
    logic [DATA_W-1:0]  rs_val;
    logic [DATA_W-1:0]  rd_val;
    logic               wr_en;
    logic [DATA_W-1:0]  wr_data;

    assign op = opcode_t'(ir[OP_MSB:OP_LSB]);
    assign rd = ir[RD_MSB:RD_LSB];
    assign rs = ir[RS_MSB:RS_LSB];

    assign mux_jump    = valid & (op == OP_JMP);
    assign jump_adress = ir[OFF_MSB:OFF_LSB];

    // Decode register. The instruction arriving while a jump is being
    // resolved was fetched from the fall-through path, so it is kept as a
    // bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir    <= '0;
            valid <= 1'b0;
        end else begin
            ir    <= instruction_code;
            valid <= ~mux_jump;
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        if (valid) begin
            case (op)
                OP_MOV: begin
                    wr_en   = 1'b1;
                    wr_data = rs_val;
                end
                OP_ADD: begin
                    wr_en   = 1'b1;
                    wr_data = rd_val + rs_val;
                end
                OP_LDI: begin
                    wr_en   = 1'b1;
                    wr_data = DATA_W'(rs);
                end
                default: begin
                    wr_en   = 1'b0;
                    wr_data = '0;
                end
            endcase
        end
    end

    register_file #(
        .DATA_W (DATA_W)
    ) u_register_file (
        .clk    (clk),
        .reset  (reset),
        .we     (wr_en),
        .wa     (rd),
        .wd     (wr_data),
        .ra_rs  (rs),
        .rd_rs  (rs_val),
        .ra_rd  (rd),
        .rd_rd  (rd_val),
        .ra_dbg (dbg_sel),
        .rd_dbg (dbg_data)
    );

    // wb_addr/wb_data hold the last write; only wb_valid pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid     <= 1'b0;
            wb_addr      <= '0;
            wb_data      <= '0;
            retire_count <= '0;
        end else begin
            wb_valid     <= wr_en;
            retire_count <= retire_count + CNT_W'(valid);
            if (wr_en) begin
                wb_addr <= rd;
                wb_data <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_decode_execute.sv
module tb_decode_execute;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  instruction_code;
    logic        mux_jump;
    logic [5:0]  jump_adress;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [7:0]  wb_data;
    logic [15:0] retire_count;
    logic [2:0]  dbg_sel;
    logic [7:0]  dbg_data;

    int checks = 0;
    int errors = 0;
    bit rand_dbg = 1'b0;

    decode_execute dut (
        .clk              (clk),
        .reset            (reset),
        .instruction_code (instruction_code),
        .mux_jump         (mux_jump),
        .jump_adress      (jump_adress),
        .wb_valid         (wb_valid),
        .wb_addr          (wb_addr),
        .wb_data          (wb_data),
        .retire_count     (retire_count),
        .dbg_sel          (dbg_sel),
        .dbg_data         (dbg_data)
    );

    always #5 clk = ~clk;

    // Fetch unit environment: program memory and PC.
    logic [7:0] mem [256];
    logic [7:0] pc;
    assign instruction_code = mem[pc];

    always @(posedge clk or negedge reset) begin
        if (!reset) pc <= 8'd0;
        else        pc <= mux_jump ? pc + {{2{jump_adress[5]}}, jump_adress} : pc + 8'd1;
    end

    // Reference model: a program-order interpreter. m_addr is the address of
    // the instruction executing this cycle (when m_valid), m_nxt the address
    // to resume at after a bubble.
    logic [7:0]  m_regs [8];
    logic        m_wbv;
    logic [2:0]  m_wba;
    logic [7:0]  m_wbd;
    logic [15:0] m_cnt;
    logic        m_valid;
    logic [7:0]  m_addr;
    logic [7:0]  m_nxt;
    wire  [7:0]  m_ins = mem[m_addr];
    wire  [2:0]  m_rd  = m_ins[5:3];
    wire  [2:0]  m_rs  = m_ins[2:0];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) m_regs[i] <= 8'd0;
            m_wbv   <= 1'b0;
            m_wba   <= 3'd0;
            m_wbd   <= 8'd0;
            m_cnt   <= 16'd0;
            m_valid <= 1'b0;
            m_addr  <= 8'd0;
            m_nxt   <= 8'd0;
        end else begin
            m_wbv <= 1'b0;
            if (m_valid) begin
                m_cnt <= m_cnt + 16'd1;
                case (m_ins[7:6])
                    2'd0: begin
                        m_regs[m_rd] <= m_regs[m_rs];
                        m_wbv <= 1'b1; m_wba <= m_rd; m_wbd <= m_regs[m_rs];
                    end
                    2'd1: begin
                        m_regs[m_rd] <= 8'(m_regs[m_rd] + m_regs[m_rs]);
                        m_wbv <= 1'b1; m_wba <= m_rd; m_wbd <= 8'(m_regs[m_rd] + m_regs[m_rs]);
                    end
                    2'd2: begin
                        m_regs[m_rd] <= {5'd0, m_rs};
                        m_wbv <= 1'b1; m_wba <= m_rd; m_wbd <= {5'd0, m_rs};
                    end
                    default: begin
                        m_valid <= 1'b0;
                        m_nxt   <= m_addr + 8'd1 + {{2{m_ins[5]}}, m_ins[5:0]};
                    end
                endcase
                if (m_ins[7:6] != 2'd3) m_addr <= m_addr + 8'd1;
            end else begin
                m_valid <= 1'b1;
                m_addr  <= m_nxt;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic exp_mj;
        exp_mj = m_valid && (m_ins[7:6] == 2'd3);
        check("mux_jump", {31'd0, mux_jump}, {31'd0, exp_mj});
        if (exp_mj) check("jump_adress", {26'd0, jump_adress}, {26'd0, m_ins[5:0]});
        check("wb_valid", {31'd0, wb_valid}, {31'd0, m_wbv});
        check("wb_addr", {29'd0, wb_addr}, {29'd0, m_wba});
        check("wb_data", {24'd0, wb_data}, {24'd0, m_wbd});
        check("retire_count", {16'd0, retire_count}, {16'd0, m_cnt});
        check("dbg_data", {24'd0, dbg_data}, {24'd0, m_regs[dbg_sel]});
        if (rand_dbg) dbg_sel = 3'($urandom);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lit_reg(input string name, input int idx, input logic [7:0] exp);
        dbg_sel = 3'(idx);
        #1;
        check(name, {24'd0, dbg_data}, {24'd0, exp});
    endtask

    task automatic lit_wb(input string name, input logic v, input logic [2:0] a, input logic [7:0] d);
        check({name, "_v"}, {31'd0, wb_valid}, {31'd0, v});
        check({name, "_a"}, {29'd0, wb_addr}, {29'd0, a});
        check({name, "_d"}, {24'd0, wb_data}, {24'd0, d});
    endtask

    task automatic enter_reset();
        @(negedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    endtask

    task automatic leave_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b0;
        dbg_sel = 3'd0;
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
        cyc(2);
        check("rst_retire", {16'd0, retire_count}, 32'd0);
        check("rst_mux", {31'd0, mux_jump}, 32'd0);
        lit_wb("rst_wb", 1'b0, 3'd0, 8'd0);

        // LDI r1,5; LDI r2,3; ADD r1,r2; MOV r3,r1
        mem[0] = 8'h8D; mem[1] = 8'h93; mem[2] = 8'h4A; mem[3] = 8'h19;
        leave_reset();
        cyc(2); lit_wb("seq0", 1'b1, 3'd1, 8'd5);
        cyc(1); lit_wb("seq1", 1'b1, 3'd2, 8'd3);
        cyc(1); lit_wb("seq2", 1'b1, 3'd1, 8'd8);
        cyc(1); lit_wb("seq3", 1'b1, 3'd3, 8'd8);
        check("seq_retire", {16'd0, retire_count}, 32'd4);
        lit_reg("seq_r1", 1, 8'd8);
        lit_reg("seq_r3", 3, 8'd8);

        // Overflow: LDI r1,4 then ADD r1,r1 six times -> 128+128 wraps to 0
        enter_reset();
        mem[0] = 8'h8C;
        for (int i = 1; i <= 6; i++) mem[i] = 8'h49;
        leave_reset();
        cyc(7); lit_wb("ovf_pre", 1'b1, 3'd1, 8'h80);
        cyc(1); lit_wb("ovf", 1'b1, 3'd1, 8'h00);
        lit_reg("ovf_r1", 1, 8'h00);

        // JMP +2 at address 4
        enter_reset();
        mem[0] = 8'h81; mem[1] = 8'h8A; mem[2] = 8'h93; mem[3] = 8'h9C;
        mem[4] = 8'hC2; mem[5] = 8'hAD; mem[6] = 8'hB6; mem[7] = 8'hBF;
        leave_reset();
        cyc(4); check("j2_pre_mux", {31'd0, mux_jump}, 32'd0);
        cyc(1); check("j2_mux", {31'd0, mux_jump}, 32'd1);
        check("j2_off", {26'd0, jump_adress}, 32'h02);
        check("j2_cnt4", {16'd0, retire_count}, 32'd4);
        cyc(1); check("j2_bubble_mux", {31'd0, mux_jump}, 32'd0);
        check("j2_cnt5", {16'd0, retire_count}, 32'd5);
        check("j2_jmp_wbv", {31'd0, wb_valid}, 32'd0);
        cyc(1); check("j2_sq_wbv", {31'd0, wb_valid}, 32'd0);
        lit_reg("j2_r5", 5, 8'd0);
        cyc(1); lit_wb("j2_tgt", 1'b1, 3'd7, 8'd7);
        check("j2_cnt6", {16'd0, retire_count}, 32'd6);
        lit_reg("j2_r6", 6, 8'd0);

        // JMP -1 at address 10
        enter_reset();
        for (int i = 0; i < 10; i++) mem[i] = 8'h80;
        leave_reset();
        cyc(11);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) cyc(1);
            check("loop_mux", {31'd0, mux_jump}, {31'd0, (i % 2) == 0});
        end
        check("loop_cnt", {16'd0, retire_count}, 32'd13);

        // JMP followed by JMP
        enter_reset();
        mem[0] = 8'hC3; mem[1] = 8'hFF; mem[4] = 8'hA4;
        leave_reset();
        cyc(1); check("jj_mux1", {31'd0, mux_jump}, 32'd1);
        cyc(1); check("jj_mux2", {31'd0, mux_jump}, 32'd0);
        cyc(1); check("jj_mux3", {31'd0, mux_jump}, 32'd0);
        cyc(1); lit_wb("jj_wb", 1'b1, 3'd4, 8'd4);
        check("jj_cnt", {16'd0, retire_count}, 32'd2);

        // Reset while a jump is being resolved
        enter_reset();
        mem[0] = 8'h81; mem[1] = 8'h8A; mem[2] = 8'h93; mem[3] = 8'h9C;
        mem[4] = 8'hC2; mem[5] = 8'hAD; mem[6] = 8'hB6; mem[7] = 8'hBF;
        leave_reset();
        cyc(5); check("rj_mux_before", {31'd0, mux_jump}, 32'd1);
        #1 reset = 1'b0;
        #1 check("rj_mux", {31'd0, mux_jump}, 32'd0);
        check("rj_cnt", {16'd0, retire_count}, 32'd0);
        lit_wb("rj_wb", 1'b0, 3'd0, 8'd0);
        for (int r = 0; r < 8; r++) lit_reg("rj_reg", r, 8'd0);
        leave_reset();
        cyc(2); lit_wb("rj_restart", 1'b1, 3'd0, 8'd1);
        check("rj_restart_cnt", {16'd0, retire_count}, 32'd1);

        // Randomized programs with occasional mid-run resets
        for (int p = 0; p < 8; p++) begin
            enter_reset();
            for (int i = 0; i < 256; i++) begin
                if (p == 7)                      mem[i] = 8'($urandom);
                else if ($urandom_range(0, 7) == 0) mem[i] = {2'b11, 6'($urandom)};
                else                             mem[i] = {2'($urandom_range(0, 2)), 6'($urandom)};
            end
            rand_dbg = 1'b1;
            leave_reset();
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                if ($urandom_range(0, 149) == 0) begin
                    #($urandom_range(1, 4)) reset = 1'b0;
                    cyc($urandom_range(1, 3));
                    reset = 1'b1;
                end
            end
            rand_dbg = 1'b0;
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
